stepdown_loop_sequencer: RTL and testbench
==========================================

// Module: stepdown_loop_sequencer
// PURPOSE
// Sequencer for the step-down loop control path. Generates the tstate enable that qualifies the
//   loop's 3-input AND gate (tstate & i0 & i1).
// Covers soft-start (phase-compare duty ramp), regulation, blanking of the overcurrent input after
//   each tstate rising edge, and hiccup retry that latches off after FAULT_MAX consecutive faults.
// Sits between the converter enable/protection logic and the loop input qualifier.
// PARAMETERS
// SS_W       6     width of soft-start phase counter and ss_level
// BLANK_CYC  4     clocks ocp is ignored after each tstate 0->1 edge (>=1)
// RETRY_CYC  1024  hiccup off-time in FAULT; also the fault-clear hold time in REGULATE (>=2)
// FAULT_MAX  3     consecutive faults that force LATCH (>=1)
// PORTS
// clk            in   1     loop control clock
// rst_n          in   1     reset; one clock; asynchronous, active-low
// en             in   1     converter enable, level, synchronous to clk
// ocp            in   1     overcurrent flag, synchronous to clk
// tstate         out  1     loop qualifier enable, registered
// ss_level       out  SS_W  current soft-start duty level, registered
// state          out  3     IDLE=0 SOFTSTART=1 REGULATE=2 FAULT=3 LATCH=4
// fault_latched  out  1     high in LATCH
// fault_cnt      out  2     consecutive fault count, saturates at FAULT_MAX
// BEHAVIOUR
// - Reset: state=IDLE; tstate=0; ss_level=0; fault_latched=0; fault_cnt=0;
//   phase=0, blank timer=0, retry timer=0.
// - phase: free-running SS_W-bit up-counter, wraps to 0; runs in every state.
// - Transition priority each cycle: en=0 > unblanked ocp > normal transition.
// - en=0 in any state: next cycle state=IDLE, tstate=0, ss_level=0, fault_cnt=0,
//   fault_latched=0, timers=0.
// - IDLE: tstate=0. en=1 -> SOFTSTART next cycle with ss_level=0.
// - SOFTSTART: tstate(N+1) = (phase(N) < ss_level(N)).
//   ss_level increments by 1 on the cycle phase wraps from all-ones to 0.
//   When phase wraps with ss_level = all-ones -> REGULATE next cycle; ss_level holds all-ones.
// - REGULATE: tstate=1.
//   Retry timer counts the ocp-free cycles spent in REGULATE.
//   After RETRY_CYC such cycles, fault_cnt clears to 0; the timer stops at that point.
// - Blanking: a tstate 0->1 edge loads the blank timer with BLANK_CYC.
//   ocp is ignored while the timer is nonzero; the timer decrements each cycle.
// - Unblanked ocp at cycle N in SOFTSTART or REGULATE:
//   state=FAULT and tstate=0 at N+1; fault_cnt++ (saturating); retry timer loads RETRY_CYC-1.
// - FAULT: tstate=0; ocp ignored; retry timer decrements to 0. At 0:
//   - fault_cnt==FAULT_MAX -> LATCH.
//   - Otherwise -> SOFTSTART with ss_level=0.
// - LATCH: tstate=0; fault_latched=1. Exits only via en=0 (-> IDLE) or rst_n.
// - ocp and en in the same cycle with en=0: IDLE wins, no fault counted.
// - Reset asserted mid-operation: all outputs take reset values immediately (asynchronous).
// - All outputs come straight from flops; no combinational path from input to output.
// TESTING (SS_W=4, BLANK_CYC=4, RETRY_CYC=16, FAULT_MAX=3)
// - Reset, then en=1: state=1 next cycle; ss_level steps 0..15 every 16 clocks;
//   state=2 after 256 clocks; tstate duty = ss_level/16 per phase window.
// - REGULATE, ocp pulse 1 cycle -> tstate=0 and state=3 next cycle; fault_cnt=1;
//   after 16 cycles state=1, ss_level=0.
// - ocp held high throughout soft-start retries -> 3rd fault -> LATCH:
//   fault_latched=1, tstate stays 0. en=0 -> IDLE, fault_cnt=0.
// - ocp asserted in the 4 cycles after a tstate rise -> ignored, state unchanged;
//   ocp on 5th cycle -> FAULT.
// - Fault, recover, 16 ocp-free cycles in REGULATE -> fault_cnt=0;
//   en=0 coincident with ocp -> IDLE, fault_cnt=0.
// - rst_n pulsed low mid-SOFTSTART -> all outputs 0 asynchronously; state=IDLE on release.

Source files
------------

// File: rtl/stepdown_loop_sequencer.sv
// Purpose: step-down loop sequencer; soft-start duty ramp, regulation, ocp blanking, hiccup retry, latch-off.
// Latency: every output is a flop, updated one clock after the en/ocp sample that causes it.
// Backpressure: none; en and ocp are level inputs sampled every clock, no handshake.
module stepdown_loop_sequencer #(
   parameter int SS_W      = 6,
   parameter int BLANK_CYC = 4,
   parameter int RETRY_CYC = 1024,
   parameter int FAULT_MAX = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            ocp,
   output logic            tstate,
   output logic [SS_W-1:0] ss_level,
   output logic [2:0]      state,
   output logic            fault_latched,
   output logic [1:0]      fault_cnt
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SOFTSTART = 3'd1,
      REGULATE  = 3'd2,
      FAULT     = 3'd3,
      LATCH     = 3'd4
   } state_t;

   localparam int BW = $clog2(BLANK_CYC + 1);
   localparam int RW = $clog2(RETRY_CYC + 1);

   localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);
   localparam logic [RW-1:0] RETRY_LOAD = RW'(RETRY_CYC - 1);
   localparam logic [RW-1:0] RETRY_DONE = RW'(RETRY_CYC);
   localparam logic [1:0]    FCNT_MAX   = 2'(FAULT_MAX);

   state_t          st;
   logic [SS_W-1:0] phase;
   logic [BW-1:0]   blank_tmr;
   logic [RW-1:0]   retry_tmr;
   logic            ocp_hit;
   logic            tstate_nxt;

   assign state = st;

   // ocp counts only while the loop is switching and the blanking window has expired
   assign ocp_hit = ocp && (blank_tmr == '0) && ((st == SOFTSTART) || (st == REGULATE));

   // next tstate: phase-compare ramp in soft-start, full enable in regulation, off otherwise
   always_comb begin
      tstate_nxt = 1'b0;
      if (en && !ocp_hit) begin
         case (st)
            SOFTSTART: tstate_nxt = (phase < ss_level);
            REGULATE:  tstate_nxt = 1'b1;
            default:   tstate_nxt = 1'b0;
         endcase
      end
   end

   // free-running phase counter for the soft-start duty compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

   // blanking window: restarted on every tstate rising edge, then counts down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_tmr <= '0;
      end else if (!en) begin
         blank_tmr <= '0;
      end else if (!tstate && tstate_nxt) begin
         blank_tmr <= BLANK_LOAD;
      end else if (blank_tmr != '0) begin
         blank_tmr <= blank_tmr - 1'b1;
      end
   end

   // sequencer FSM; retry_tmr is the hiccup off-timer in FAULT and the fault-clear timer in REGULATE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= IDLE;
         tstate        <= 1'b0;
         ss_level      <= '0;
         fault_latched <= 1'b0;
         fault_cnt     <= 2'd0;
         retry_tmr     <= '0;
      end else begin
         tstate <= tstate_nxt;
         if (!en) begin
            st            <= IDLE;
            ss_level      <= '0;
            fault_latched <= 1'b0;
            fault_cnt     <= 2'd0;
            retry_tmr     <= '0;
         end else if (ocp_hit) begin
            st        <= FAULT;
            retry_tmr <= RETRY_LOAD;
            if (fault_cnt != FCNT_MAX) begin
               fault_cnt <= fault_cnt + 1'b1;
            end
         end else begin
            case (st)
               IDLE: begin
                  st       <= SOFTSTART;
                  ss_level <= '0;
               end
               SOFTSTART: begin
                  if (&phase) begin
                     if (&ss_level) begin
                        st <= REGULATE;
                     end else begin
                        ss_level <= ss_level + 1'b1;
                     end
                  end
               end
               REGULATE: begin
                  // a long enough clean run forgives earlier faults; timer parks at the limit
                  if (!ocp && (retry_tmr != RETRY_DONE)) begin
                     retry_tmr <= retry_tmr + 1'b1;
                     if (retry_tmr == RETRY_LOAD) begin
                        fault_cnt <= 2'd0;
                     end
                  end
               end
               FAULT: begin
                  if (retry_tmr == '0) begin
                     if (fault_cnt == FCNT_MAX) begin
                        st            <= LATCH;
                        fault_latched <= 1'b1;
                     end else begin
                        st       <= SOFTSTART;
                        ss_level <= '0;
                     end
                  end else begin
                     retry_tmr <= retry_tmr - 1'b1;
                  end
               end
               LATCH: begin
                  fault_latched <= 1'b1;
               end
               default: begin
                  st <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stepdown_loop_sequencer.sv
// Purpose: scoreboard bench for stepdown_loop_sequencer with SS_W=4, BLANK_CYC=4, RETRY_CYC=16, FAULT_MAX=3.
// Latency: expectations are tagged with the clock count at which the DUT must show them.
// Backpressure: none; the monitor samples every falling edge and pops entries due at that count.
module tb_stepdown_loop_sequencer;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       ocp;
   logic       tstate;
   logic [3:0] ss_level;
   logic [2:0] state;
   logic       fault_latched;
   logic [1:0] fault_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base   = 0;
   bit started = 1'b0;

   typedef struct {
      int    cyc;
      string tag;
      int    st;
      int    ts;
      int    ss;
      int    fl;
      int    fc;
   } exp_t;

   exp_t sb[$];

   stepdown_loop_sequencer #(
      .SS_W      (4),
      .BLANK_CYC (4),
      .RETRY_CYC (16),
      .FAULT_MAX (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .ocp           (ocp),
      .tstate        (tstate),
      .ss_level      (ss_level),
      .state         (state),
      .fault_latched (fault_latched),
      .fault_cnt     (fault_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // clock counter used to tag expectations
   always @(posedge clk) cyc <= cyc + 1;

   // -1 in any field means "not checked at this cycle"
   function automatic void expect_at(int k, string tag, int st, int ts, int ss, int fl, int fc);
      exp_t e;
      e.cyc = base + k;
      e.tag = tag;
      e.st  = st;
      e.ts  = ts;
      e.ss  = ss;
      e.fl  = fl;
      e.fc  = fc;
      sb.push_back(e);
   endfunction

   task automatic cmp(string tag, string fld, int k, logic [7:0] got, int want);
      if (want >= 0) begin
         checks++;
         if (got !== 8'(want)) begin
            errors++;
            $display("FAIL %s %s at cycle %0d: got %0d required %0d", tag, fld, k, got, want);
         end
      end
   endtask

   // monitor: compare the DUT against every scoreboard entry due at this clock count
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
               exp_t e;
               e = sb.pop_front();
               if (e.cyc < cyc) begin
                  checks++;
                  errors++;
                  $display("FAIL %s missed: due cycle %0d, now %0d", e.tag, e.cyc - base, cyc - base);
               end else begin
                  cmp(e.tag, "state",         e.cyc - base, 8'(state),         e.st);
                  cmp(e.tag, "tstate",        e.cyc - base, 8'(tstate),        e.ts);
                  cmp(e.tag, "ss_level",      e.cyc - base, 8'(ss_level),      e.ss);
                  cmp(e.tag, "fault_latched", e.cyc - base, 8'(fault_latched), e.fl);
                  cmp(e.tag, "fault_cnt",     e.cyc - base, 8'(fault_cnt),     e.fc);
               end
            end
         end
      end
   end

   // advance to 1 time unit after the clock edge that makes the count equal base+k
   task automatic goto(int k);
      if (cyc > base + k) begin
         $display("FAIL goto: cycle %0d already passed, now %0d", k, cyc - base);
         $fatal(1, "stimulus schedule broken");
      end
      while (cyc != base + k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int m;
      rst_n = 1'b0;
      en    = 1'b0;
      ocp   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base  = cyc;

      // reset values and idle with en low
      expect_at(0,  "reset", 0, 0, 0, 0, 0);
      expect_at(15, "idle",  0, 0, 0, 0, 0);
      // soft-start from phase 0: ss steps every 16 clocks, tstate(N+1) = phase(N) < ss(N)
      for (m = 0; m < 256; m++) begin
         expect_at(16 + m, "softstart", 1,
                   (m == 0) ? 0 : ((((m - 1) % 16) < ((m - 1) / 16)) ? 1 : 0),
                   m / 16, 0, 0);
      end
      expect_at(272, "reg_entry",  2, 0, 15, 0, 0);
      // ocp high from the tstate rise: blanked for 4 cycles, trips on the 5th
      expect_at(273, "blank1", 2, 1, 15, 0, 0);
      expect_at(274, "blank2", 2, 1, 15, 0, 0);
      expect_at(275, "blank3", 2, 1, 15, 0, 0);
      expect_at(276, "blank4", 2, 1, 15, 0, 0);
      expect_at(277, "blank5", 2, 1, 15, 0, 0);
      expect_at(278, "blank_trip", 3, 0, -1, 0, 1);
      expect_at(293, "hiccup_end", 3, 0, -1, 0, 1);
      expect_at(294, "retry_ss",   1, 0, 0, 0, 1);
      // second soft-start from phase 6, regulation at 544, fault count forgiven after 16 clean cycles
      expect_at(543, "ss_top",     1, -1, 15, 0, 1);
      expect_at(544, "reg2_entry", 2, 0, 15, 0, 1);
      expect_at(545, "reg2_on",    2, 1, 15, 0, 1);
      expect_at(559, "clr_before", 2, 1, 15, 0, 1);
      expect_at(560, "clr_after",  2, 1, 15, 0, 0);
      // single-cycle ocp pulse in regulation
      expect_at(570, "pulse_pre",  2, 1, 15, 0, 0);
      expect_at(571, "pulse_trip", 3, 0, -1, 0, 1);
      expect_at(586, "pulse_hold", 3, 0, -1, 0, 1);
      expect_at(587, "pulse_ss",   1, 0, 0, 0, 1);
      // ocp stuck high: faults 2 and 3, then latch-off
      expect_at(588, "stuck_f2",   3, 0, -1, 0, 2);
      expect_at(603, "stuck_h2",   3, 0, -1, 0, 2);
      expect_at(604, "stuck_ss2",  1, 0, 0, 0, 2);
      expect_at(605, "stuck_f3",   3, 0, -1, 0, 3);
      expect_at(620, "stuck_h3",   3, 0, -1, 0, 3);
      expect_at(621, "latch",      4, 0, -1, 1, 3);
      expect_at(630, "latch_hold", 4, 0, -1, 1, 3);
      expect_at(631, "latch_off",  0, 0, 0, 0, 0);
      // en low coincident with ocp while a fault is on record
      expect_at(641, "re_en",      1, 0, 0, 0, 0);
      expect_at(642, "ss_fault",   3, 0, -1, 0, 1);
      expect_at(657, "ss_hold",    3, 0, -1, 0, 1);
      expect_at(658, "ss_back",    1, 0, 0, 0, 1);
      expect_at(660, "pre_dis",    1, 0, 0, 0, 1);
      expect_at(661, "dis_ocp",    0, 0, 0, 0, 0);
      expect_at(662, "dis_ocp2",   0, 0, 0, 0, 0);
      // asynchronous reset during soft-start
      expect_at(700, "pre_rst",    1, 0, 2, 0, 0);
      expect_at(701, "async_rst",  0, 0, 0, 0, 0);
      expect_at(702, "rst_rel",    0, 0, 0, 0, 0);
      expect_at(703, "post_rst",   1, 0, 0, 0, 0);
      started = 1'b1;

      goto(15);  en  = 1'b1;
      goto(273); ocp = 1'b1;
      goto(278); ocp = 1'b0;
      goto(570); ocp = 1'b1;
      goto(571); ocp = 1'b0;
      goto(587); ocp = 1'b1;
      goto(630); en  = 1'b0; ocp = 1'b0;
      goto(640); en  = 1'b1;
      goto(641); ocp = 1'b1;
      goto(642); ocp = 1'b0;
      goto(660); en  = 1'b0; ocp = 1'b1;
      goto(662); ocp = 1'b0;
      goto(670); en  = 1'b1;
      goto(701); #1 rst_n = 1'b0;
      goto(702); #1 rst_n = 1'b1;
      goto(710);

      repeat (5) begin
         if (sb.size() != 0) @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
